// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the byte-serial memory arbiter
//   Size encodings, FSM state enum, requester ids, store alignment and
//   load extension helpers used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Index of the last beat (beat count minus one) for a size encoding.
    function automatic logic [1:0] beats_m1(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Move right-justified store data so the first beat's byte sits in [31:24].
    function automatic logic [31:0] align_store(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {wdata[7:0], 24'h0};
            SZ_HALF: return {wdata[15:0], 16'h0};
            default: return wdata;
        endcase
    endfunction

    // Raw holds bytes MSB-first with the final byte in [7:0].
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                                input logic [31:0] raw);
        case (size)
            SZ_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way round-robin picker for fetch vs. data requests
//   clk, rst      : clock, asynchronous active-high reset
//   if_req, d_req : pending requests
//   en            : arbitration window (arbiter idle); rr_last updates only here
//   gnt_valid     : at least one request pending
//   gnt_d         : 1 = data requester wins, 0 = fetch wins
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic en,
    output logic gnt_valid,
    output logic gnt_d
);

    req_id_t rr_last;
    req_id_t gnt_id;

    always_comb begin
        gnt_valid = if_req | d_req;
        if (if_req && d_req) begin
            gnt_id = (rr_last == REQ_D) ? REQ_IF : REQ_D;
        end else if (if_req) begin
            gnt_id = REQ_IF;
        end else begin
            gnt_id = REQ_D;
        end
    end

    assign gnt_d = (gnt_id == REQ_D);

    // Reset to DATA so fetch wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= REQ_D;
        end else if (en && gnt_valid) begin
            rr_last <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares a byte-wide single-port RAM between fetch and load/store
//   if_*  : fetch port (word reads), req held until one-cycle if_ack
//   d_*   : load/store port (byte/half/word, sign/zero extended loads)
//   mem_* : byte RAM interface, read data valid the cycle after a read beat
//   busy  : FSM not in IDLE
// Accesses are split into big-endian byte beats, lowest address first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t            state;
    req_id_t           owner;
    logic              cur_we;
    logic [1:0]        cur_size;
    logic              cur_signed;
    logic [ADDR_W-1:0] base;
    logic [1:0]        cnt;
    logic [1:0]        last;
    logic [1:0]        cnt_nx;
    // Store: remaining bytes to send at [31:24]. Load: captured bytes shift in at [7:0].
    logic [31:0]       shreg;

    logic              gnt_valid;
    logic              gnt_d;
    req_id_t           gnt_id;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_signed;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_bad;
    logic [31:0]       aligned;
    logic [31:0]       raw;
    logic [31:0]       result;

    mem_arb_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .d_req     (d_req),
        .en        (state == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_d     (gnt_d)
    );

    assign gnt_id = gnt_d ? REQ_D : REQ_IF;

    always_comb begin
        if (gnt_id == REQ_IF) begin
            sel_we     = 1'b0;
            sel_size   = SZ_WORD;
            sel_signed = 1'b0;
            sel_addr   = if_addr;
            sel_wdata  = 32'h0;
        end else begin
            sel_we     = d_we;
            sel_size   = d_size;
            sel_signed = d_signed;
            sel_addr   = d_addr;
            sel_wdata  = d_wdata;
        end
        sel_bad = (sel_size == SZ_RSVD)
               || (sel_size == SZ_HALF && sel_addr[0])
               || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00)
               || ((sel_addr >> ADDR_W) != 32'd0);
    end

    assign aligned = align_store(sel_size, sel_wdata);
    assign cnt_nx  = cnt + 2'd1;
    assign raw     = {shreg[23:0], mem_rdata};
    assign result  = (owner == REQ_IF) ? raw : load_extend(cur_size, cur_signed, raw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= REQ_IF;
            cur_we     <= 1'b0;
            cur_size   <= SZ_BYTE;
            cur_signed <= 1'b0;
            base       <= '0;
            cnt        <= 2'd0;
            last       <= 2'd0;
            shreg      <= 32'h0;
            if_ack     <= 1'b0;
            if_rdata   <= 32'h0;
            if_err     <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= 32'h0;
            d_err      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        busy       <= 1'b1;
                        owner      <= gnt_id;
                        cur_we     <= sel_we;
                        cur_size   <= sel_size;
                        cur_signed <= sel_signed;
                        if (sel_bad) begin
                            state <= ACK;
                            if (gnt_id == REQ_IF) begin
                                if_ack   <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= 32'h0;
                            end else begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= 32'h0;
                            end
                        end else begin
                            // First beat goes out in the cycle right after the grant.
                            state     <= ISSUE;
                            cnt       <= 2'd0;
                            last      <= beats_m1(sel_size);
                            base      <= sel_addr[ADDR_W-1:0];
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr[ADDR_W-1:0];
                            mem_wdata <= aligned[31:24];
                            shreg     <= sel_we ? {aligned[23:0], 8'h0} : 32'h0;
                        end
                    end
                end
                ISSUE: begin
                    // Beat cnt is on the bus; read data for beat cnt-1 is arriving.
                    if (!cur_we && cnt != 2'd0) begin
                        shreg <= {shreg[23:0], mem_rdata};
                    end
                    if (cnt == last) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (cur_we) begin
                            state   <= ACK;
                            d_ack   <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= 32'h0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt      <= cnt_nx;
                        mem_addr <= base + ADDR_W'(cnt_nx);
                        if (cur_we) begin
                            mem_wdata <= shreg[31:24];
                            shreg     <= {shreg[23:0], 8'h0};
                        end
                    end
                end
                DRAIN: begin
                    state <= ACK;
                    if (owner == REQ_IF) begin
                        if_ack   <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= result;
                    end else begin
                        d_ack   <= 1'b1;
                        d_err   <= 1'b0;
                        d_rdata <= result;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [1:0]        d_size = 2'b00;
    logic              d_signed = 1'b0;
    logic [31:0]       d_addr = 32'h0;
    logic [31:0]       d_wdata = 32'h0;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_signed  (d_signed),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural byte RAM; pre_* lets the bench preload it.
    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [7:0]        pre_data = 8'h0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          cyc;
    } exp_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        data;
    } beat_t;

    exp_t  exp_if[$];
    exp_t  exp_d[$];
    beat_t beats[$];
    int    order[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    last_issue = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mem_en) beats.push_back('{cyc, mem_addr, mem_we, mem_wdata});
        if (if_ack) begin
            order.push_back(0);
            if (exp_if.size() == 0) begin
                flag("if_ack unexpected");
            end else begin
                e = exp_if.pop_front();
                check("if_err", {31'h0, if_err}, {31'h0, e.err});
                if (e.chk_data) check("if_rdata", if_rdata, e.data);
                if (e.cyc >= 0) check("if_ack_cycle", cyc, e.cyc);
            end
        end
        if (d_ack) begin
            order.push_back(1);
            if (exp_d.size() == 0) begin
                flag("d_ack unexpected");
            end else begin
                e = exp_d.pop_front();
                check("d_err", {31'h0, d_err}, {31'h0, e.err});
                if (e.chk_data) check("d_rdata", d_rdata, e.data);
                if (e.cyc >= 0) check("d_ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int lat);
        bit got = 0;
        if_req  = 1'b1;
        if_addr = addr;
        last_issue = cyc;
        exp_if.push_back('{exp_data, exp_err, 1'b1, (lat < 0) ? -1 : cyc + lat});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_ack) begin got = 1; break; end
        end
        if (!got) flag("if_ack timeout");
        tick();
        if_req = 1'b0;
    endtask

    task automatic dacc(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic chk, input int lat);
        bit got = 0;
        d_req    = 1'b1;
        d_we     = we;
        d_size   = size;
        d_signed = sgn;
        d_addr   = addr;
        d_wdata  = wdata;
        last_issue = cyc;
        exp_d.push_back('{exp_data, exp_err, chk, (lat < 0) ? -1 : cyc + lat});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_ack) begin got = 1; break; end
        end
        if (!got) flag("d_ack timeout");
        tick();
        d_req = 1'b0;
    endtask

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset mem_en", {31'h0, mem_en}, 32'h0);
        check("reset acks", {30'h0, if_ack, d_ack}, 32'h0);
        check("reset if_rdata", if_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        check("reset mem_addr", {22'h0, mem_addr}, 32'h0);
        tick();

        poke(10'h010, 8'h12); poke(10'h011, 8'h34); poke(10'h012, 8'h56); poke(10'h013, 8'h78);
        poke(10'h040, 8'h11); poke(10'h041, 8'h22); poke(10'h042, 8'h33); poke(10'h043, 8'h44);

        // Word fetch: beats at cycles 1..4, ack at 6.
        beats.delete();
        fetch(32'h10, 32'h12345678, 1'b0, 6);
        check("fetch beat count", beats.size(), 4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check("fetch beat addr", {22'h0, beats[k].addr}, 32'h10 + k);
            check("fetch beat cycle", beats[k].cyc, last_issue + 1 + k);
            check("fetch beat we", {31'h0, beats[k].we}, 32'h0);
        end

        // Half store then signed / unsigned half loads.
        dacc(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 1'b0, 3);
        check("ram[0x22]", {24'h0, ram[10'h022]}, 32'hBE);
        check("ram[0x23]", {24'h0, ram[10'h023]}, 32'hEF);
        dacc(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1, 4);
        dacc(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, 1'b1, 4);

        // Byte store at top of RAM: one write beat, ack at cycle 2.
        beats.delete();
        dacc(1'b1, SZ_BYTE, 1'b0, 32'h3FF, 32'h123456A5, 32'h0, 1'b0, 1'b0, 2);
        check("byte store beats", beats.size(), 1);
        if (beats.size() > 0) begin
            check("byte store addr", {22'h0, beats[0].addr}, 32'h3FF);
            check("byte store we", {31'h0, beats[0].we}, 32'h1);
            check("byte store data", {24'h0, beats[0].data}, 32'hA5);
        end
        check("ram[0x3FF]", {24'h0, ram[10'h3FF]}, 32'hA5);
        dacc(1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0, 32'h000000A5, 1'b0, 1'b1, 3);
        dacc(1'b0, SZ_BYTE, 1'b1, 32'h3FF, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1, 3);

        // Error cases: ack at cycle 1, err set, rdata cleared, no RAM beat.
        beats.delete();
        dacc(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        dacc(1'b0, SZ_RSVD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        fetch(32'h400, 32'h0, 1'b1, 1);
        check("error beats", beats.size(), 0);

        // Reset during beat 2 of a word store.
        d_req = 1'b1; d_we = 1'b1; d_size = SZ_WORD; d_signed = 1'b0;
        d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst mem_en", {31'h0, mem_en}, 32'h0);
        check("rst d_ack", {31'h0, d_ack}, 32'h0);
        tick();
        rst = 1'b0;
        check("ram[0x40]", {24'h0, ram[10'h040]}, 32'hDE);
        check("ram[0x41]", {24'h0, ram[10'h041]}, 32'hAD);
        check("ram[0x42]", {24'h0, ram[10'h042]}, 32'h33);
        check("ram[0x43]", {24'h0, ram[10'h043]}, 32'h44);
        dacc(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'hDEAD3344, 1'b0, 1'b1, 6);

        // Contention: both ports hold three back-to-back requests.
        order.delete();
        fork
            begin
                fetch(32'h10, 32'h12345678, 1'b0, -1);
                fetch(32'h10, 32'h12345678, 1'b0, -1);
                fetch(32'h10, 32'h12345678, 1'b0, -1);
            end
            begin
                dacc(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1, -1);
                dacc(1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0, 32'h000000A5, 1'b0, 1'b1, -1);
                dacc(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'hDEAD3344, 1'b0, 1'b1, -1);
            end
        join
        check("grant count", order.size(), 6);
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            check("grant order", order[k], exp_order[k]);
        end

        repeat (4) tick();
        check("if scoreboard empty", exp_if.size(), 0);
        check("d scoreboard empty", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
